// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus arbiter.
//   GM_*         encodings of granted_master (one-hot by master index)
//   SPLIT_*      bit offsets of a slave's pair inside split_request
//   arb_state_t  arbiter FSM state encoding
//   sel_width()  width of a slave index for a given slave count
package bus_pkg;

  localparam logic [1:0] GM_NONE = 2'b00;
  localparam logic [1:0] GM_M1   = 2'b01;
  localparam logic [1:0] GM_M2   = 2'b10;

  localparam int SPLIT_PULSE = 0;
  localparam int SPLIT_READY = 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY     = 2'd1,
    ST_HANDOVER = 2'd2
  } arb_state_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_rr_select.sv
// Combinational two-way round-robin picker with resume priority.
//   eligible  in   2  masters that may take the bus ([0]=M1, [1]=M2)
//   resume    in   2  subset of eligible returning from a split park
//   rr_last   in   1  master granted last (0=M1, 1=M2)
//   winner    out  2  one-hot winning master, 00 when nobody is eligible
module arb_rr_select
  import bus_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic [1:0] resume,
  input  logic       rr_last,
  output logic [1:0] winner
);

  logic [1:0] cand;

  always_comb begin
    // Parked masters coming back outrank fresh requesters.
    cand   = (|resume) ? resume : eligible;
    winner = GM_NONE;
    case (cand)
      2'b01:   winner = GM_M1;
      2'b10:   winner = GM_M2;
      2'b11:   winner = rr_last ? GM_M1 : GM_M2;
      default: winner = GM_NONE;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Central arbiter for the serial system bus: shares the bus between two
// masters, supports split (park/resume) transactions and revokes grants
// that overrun a watchdog.
//   clock50         in   1             system clock, rising edge
//   reset           in   1             synchronous, active-low
//   m_req           in   2             per-master request level
//   m_done          in   2             per-master completion pulse
//   split_request   in   2*NUM_SLAVES  per slave: [2s]=split pulse, [2s+1]=ready
//   granted_master  out  2             00 none, 01 M1, 10 M2 (registered)
//   split_pending   out  2             per-master parked flag
//   timeout_err     out  1             pulse when the watchdog revokes a grant
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | bus free, arbitrate every cycle
// ST_BUSY     | granted_master owns the bus, watchdog running
// ST_HANDOVER | one dead cycle with no owner, arbitrates for the next grant
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES = 3,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 8
) (
  input  logic                    clock50,
  input  logic                    reset,
  input  logic [1:0]              m_req,
  input  logic [1:0]              m_done,
  input  logic [2*NUM_SLAVES-1:0] split_request,
  output logic [1:0]              granted_master,
  output logic [1:0]              split_pending,
  output logic                    timeout_err
);

  localparam int SS_W = sel_width(NUM_SLAVES);
  localparam int SS_N = 1 << SS_W;

  arb_state_t state, state_nxt;

  logic [CNT_W-1:0] wd_cnt, wd_nxt;
  logic [SS_W-1:0]  ss_m1, ss_m2, ss_m1_nxt, ss_m2_nxt;
  logic [1:0]       gm_nxt, pend_nxt;
  logic             to_nxt;
  logic             rr_last, rr_nxt;

  logic [SS_N-1:0]  ready_v;
  logic [NUM_SLAVES-1:0] pulse_v;
  logic             split_any;
  logic [SS_W-1:0]  split_idx;
  logic [1:0]       resume, eligible, winner;
  logic             owner_end;

  always_comb begin
    ready_v = '0;
    pulse_v = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      pulse_v[s] = split_request[2*s + SPLIT_PULSE];
      ready_v[s] = split_request[2*s + SPLIT_READY];
    end
    split_any = |pulse_v;
    split_idx = '0;
    for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
      if (pulse_v[s]) split_idx = SS_W'(s);
    end
  end

  // Only the ready bit of the slave that parked a master can bring it back.
  assign resume[0] = split_pending[0] & ready_v[ss_m1];
  assign resume[1] = split_pending[1] & ready_v[ss_m2];
  assign eligible  = resume | (m_req & ~split_pending);
  assign owner_end = |(granted_master & (m_done | ~m_req));

  arb_rr_select u_rr_select (
    .eligible (eligible),
    .resume   (resume),
    .rr_last  (rr_last),
    .winner   (winner)
  );

  always_comb begin
    state_nxt = state;
    gm_nxt    = granted_master;
    pend_nxt  = split_pending;
    ss_m1_nxt = ss_m1;
    ss_m2_nxt = ss_m2;
    wd_nxt    = wd_cnt;
    to_nxt    = 1'b0;
    rr_nxt    = rr_last;
    case (state)
      ST_IDLE, ST_HANDOVER: begin
        if (|winner) begin
          state_nxt = ST_BUSY;
          gm_nxt    = winner;
          wd_nxt    = CNT_W'(TIMEOUT - 1);
          rr_nxt    = winner[1];
          pend_nxt  = split_pending & ~(winner & resume);
        end else begin
          state_nxt = ST_IDLE;
          gm_nxt    = GM_NONE;
        end
      end
      ST_BUSY: begin
        // Split outranks the watchdog, which outranks a normal end.
        if (split_any) begin
          pend_nxt = split_pending | granted_master;
          if (granted_master[0]) ss_m1_nxt = split_idx;
          if (granted_master[1]) ss_m2_nxt = split_idx;
          state_nxt = ST_HANDOVER;
          gm_nxt    = GM_NONE;
        end else if (wd_cnt == '0) begin
          to_nxt    = 1'b1;
          state_nxt = ST_HANDOVER;
          gm_nxt    = GM_NONE;
        end else if (owner_end) begin
          state_nxt = ST_HANDOVER;
          gm_nxt    = GM_NONE;
        end else begin
          wd_nxt = wd_cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        gm_nxt    = GM_NONE;
      end
    endcase
  end

  always_ff @(posedge clock50) begin
    if (!reset) begin
      state          <= ST_IDLE;
      granted_master <= GM_NONE;
      split_pending  <= 2'b00;
      timeout_err    <= 1'b0;
      wd_cnt         <= '0;
      rr_last        <= 1'b1;
      ss_m1          <= '0;
      ss_m2          <= '0;
    end else begin
      state          <= state_nxt;
      granted_master <= gm_nxt;
      split_pending  <= pend_nxt;
      timeout_err    <= to_nxt;
      wd_cnt         <= wd_nxt;
      rr_last        <= rr_nxt;
      ss_m1          <= ss_m1_nxt;
      ss_m2          <= ss_m2_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int NS = 3;
  localparam int TO = 8;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      m_req, m_done;
  logic [2*NS-1:0] split_req;
  logic [1:0]      gm, pend;
  logic            to_err;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_SLAVES(NS), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock50        (clk),
    .reset          (rst),
    .m_req          (m_req),
    .m_done         (m_done),
    .split_request  (split_req),
    .granted_master (gm),
    .split_pending  (pend),
    .timeout_err    (to_err)
  );

  // Reference model: owner as 0/1/2, age counts owned cycles upward.
  int         mo_owner, mo_age, mo_last;
  logic [1:0] mo_pend;
  int         mo_slave [2];
  logic       mo_to;

  function automatic int pick(input bit r0, input bit r1, input bit f0,
                              input bit f1, input int last);
    bit c0, c1;
    if (r0 || r1) begin c0 = r0; c1 = r1; end
    else          begin c0 = f0; c1 = f1; end
    if (c0 && c1) return (last == 1) ? 2 : 1;
    if (c0) return 1;
    if (c1) return 2;
    return 0;
  endfunction

  function automatic logic [1:0] model_gm();
    return (mo_owner == 1) ? 2'b01 : (mo_owner == 2) ? 2'b10 : 2'b00;
  endfunction

  always @(posedge clk) begin : model
    int  o, sp, w;
    bit  r [2];
    bit  f [2];
    if (!rst) begin
      mo_owner = 0; mo_age = 0; mo_last = 2; mo_pend = 2'b00;
      mo_slave[0] = 0; mo_slave[1] = 0; mo_to = 1'b0;
    end else begin
      mo_to = 1'b0;
      if (mo_owner != 0) begin
        o  = mo_owner - 1;
        sp = -1;
        for (int s = NS - 1; s >= 0; s--) if (split_req[2*s]) sp = s;
        if (sp >= 0) begin
          mo_pend[o]  = 1'b1;
          mo_slave[o] = sp;
          mo_owner    = 0;
        end else if (mo_age + 1 == TO) begin
          mo_to    = 1'b1;
          mo_owner = 0;
        end else if (m_done[o] || !m_req[o]) begin
          mo_owner = 0;
        end else begin
          mo_age++;
        end
      end else begin
        for (int m = 0; m < 2; m++) begin
          r[m] = mo_pend[m] && split_req[2*mo_slave[m] + 1];
          f[m] = m_req[m] && !mo_pend[m];
        end
        w = pick(r[0], r[1], f[0], f[1], mo_last);
        if (w != 0) begin
          if (r[w-1]) mo_pend[w-1] = 1'b0;
          mo_owner = w;
          mo_age   = 0;
          mo_last  = w;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_gm",   gm,            model_gm());
      chk("cyc_pend", pend,          mo_pend);
      chk("cyc_to",   {1'b0, to_err}, {1'b0, mo_to});
    end
  end

  // Literal expectations, applied to both the DUT and the model.
  task automatic lit(input string nm, input logic [1:0] e_gm,
                     input logic [1:0] e_pend, input logic e_to);
    chk({nm, "_gm"},         gm,             e_gm);
    chk({nm, "_pend"},       pend,           e_pend);
    chk({nm, "_to"},         {1'b0, to_err}, {1'b0, e_to});
    chk({nm, "_model_gm"},   model_gm(),     e_gm);
    chk({nm, "_model_pend"}, mo_pend,        e_pend);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; m_req = 2'b00; m_done = 2'b00; split_req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [1:0] t2_exp [9];

  initial begin
    rst = 1'b0; m_req = 2'b00; m_done = 2'b00; split_req = '0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    lit("reset", 2'b00, 2'b00, 1'b0);

    // 1: single request, done, handover, idle
    do_reset();
    m_req = 2'b01;
    @(negedge clk); lit("t1_grant", 2'b01, 2'b00, 1'b0); m_done = 2'b01;
    @(negedge clk); lit("t1_ho", 2'b00, 2'b00, 1'b0); m_done = 2'b00; m_req = 2'b00;
    @(negedge clk); lit("t1_idle", 2'b00, 2'b00, 1'b0);

    // 2: both requesting, alternate with one dead cycle between owners
    t2_exp = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    do_reset();
    m_req = 2'b11;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      m_done = 2'b00;
      chk("t2_seq", gm, t2_exp[k]);
      if (k == 2) m_done = 2'b01;
      if (k == 6) m_done = 2'b10;
    end
    m_req = 2'b00;

    // 3: M1 parked on slave1, M2 runs, M1 waits for M2 to finish
    do_reset();
    m_req = 2'b01;
    @(negedge clk); lit("t3_m1", 2'b01, 2'b00, 1'b0); split_req[2] = 1'b1; m_req = 2'b11;
    @(negedge clk); lit("t3_park", 2'b00, 2'b01, 1'b0); split_req[2] = 1'b0;
    @(negedge clk); lit("t3_m2", 2'b10, 2'b01, 1'b0); split_req[3] = 1'b1;
    @(negedge clk); lit("t3_wait", 2'b10, 2'b01, 1'b0); m_done = 2'b10;
    @(negedge clk); lit("t3_ho", 2'b00, 2'b01, 1'b0); m_done = 2'b00;
    @(negedge clk); lit("t3_resume", 2'b01, 2'b00, 1'b0);
    m_req = 2'b00; split_req = '0;

    // 4: watchdog revokes after TO owned cycles, then regrants
    do_reset();
    m_req = 2'b01;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk); lit("t4_busy", 2'b01, 2'b00, 1'b0);
    end
    @(negedge clk); lit("t4_timeout", 2'b00, 2'b00, 1'b1);
    @(negedge clk); lit("t4_regrant", 2'b01, 2'b00, 1'b0);
    m_req = 2'b00;

    // 5: split and done together, then reset mid-grant
    do_reset();
    m_req = 2'b01;
    @(negedge clk); lit("t5_m1", 2'b01, 2'b00, 1'b0); split_req[0] = 1'b1; m_done = 2'b01;
    @(negedge clk); lit("t5_split_done", 2'b00, 2'b01, 1'b0);
    split_req = '0; m_done = 2'b00; m_req = 2'b10;
    @(negedge clk); lit("t5_m2", 2'b10, 2'b01, 1'b0); rst = 1'b0;
    @(negedge clk); lit("t5_reset", 2'b00, 2'b00, 1'b0); rst = 1'b1; m_req = 2'b00;

    // 6: both parked on slaves 0 and 2, only slave2 ready
    do_reset();
    m_req = 2'b01;
    @(negedge clk); lit("t6_m1", 2'b01, 2'b00, 1'b0); split_req[0] = 1'b1; m_req = 2'b11;
    @(negedge clk); lit("t6_park1", 2'b00, 2'b01, 1'b0); split_req[0] = 1'b0;
    @(negedge clk); lit("t6_m2", 2'b10, 2'b01, 1'b0); split_req[4] = 1'b1;
    @(negedge clk); lit("t6_both", 2'b00, 2'b11, 1'b0); split_req[4] = 1'b0;
    @(negedge clk); lit("t6_idle", 2'b00, 2'b11, 1'b0); split_req[5] = 1'b1;
    @(negedge clk); lit("t6_resume2", 2'b10, 2'b01, 1'b0);
    @(negedge clk); lit("t6_m1_wait", 2'b10, 2'b01, 1'b0);
    m_req = 2'b00; split_req = '0;

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 7) == 0) m_req[m] = ~m_req[m];
        m_done[m] = ($urandom_range(0, 5) == 0);
      end
      for (int s = 0; s < NS; s++) begin
        split_req[2*s] = ($urandom_range(0, 23) == 0);
        if ($urandom_range(0, 5) == 0) split_req[2*s+1] = ~split_req[2*s+1];
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
